// File: rtl/ni_tx_injector_pkg.sv
// Shared types for the network-interface transmit injector.
// Holds the injector FSM encoding and the ack resynchroniser depth.
package ni_tx_injector_pkg;

  typedef enum logic [1:0] {NI_IDLE, NI_SETUP, NI_WAIT} ni_tx_state_t;

  localparam int NI_SYNC_STAGES = 2;

endpackage

// File: rtl/ni_tx_injector_if.sv
// Processor-side valid/ready and router-side 2-phase req/ack bundle.
// The slave modport is the injector; the master modport is its environment.
interface ni_tx_injector_if #(
  parameter int n    = 32,
  parameter int maxx = 1,
  parameter int maxy = 1
);
  logic                   in_valid;
  logic                   in_ready;
  logic [maxx-1:0]        in_dst_x;
  logic [maxy-1:0]        in_dst_y;
  logic [n-maxx-maxy-1:0] in_payload;
  logic                   out_req;
  logic                   out_ack;
  logic [n-1:0]           out_data;

  modport master (
    output in_valid, in_dst_x, in_dst_y, in_payload, out_ack,
    input  in_ready, out_req, out_data
  );

  modport slave (
    input  in_valid, in_dst_x, in_dst_y, in_payload, out_ack,
    output in_ready, out_req, out_data
  );
endinterface

// File: rtl/ni_tx_injector_fifo.sv
// Synchronous FIFO (module ni_tx_fifo) with registered occupancy count.
// Storage is not reset; only pointers and count are.
module ni_tx_fifo
  import ni_tx_injector_pkg::*;
#(
  parameter int width = 32,
  parameter int depth = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [width-1:0]         wdata,
  output logic [width-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(depth):0]   count
);
  localparam int PW = $clog2(depth);
  localparam logic [PW:0] FULL_CNT = depth[PW:0];

  logic [width-1:0] mem_q [depth];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [PW:0]      count_q, count_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);
  assign count = count_q;

  a_no_overflow:  assert property (@(posedge clk) disable iff (rst) !(push && full));
  a_no_underflow: assert property (@(posedge clk) disable iff (rst) !(pop && empty));

endmodule

// File: rtl/ni_tx_injector.sv
// Network-interface transmitter: FIFO-buffered packets issued as 2-phase req/ack.
// Optional macro NI_TX_TIMEOUT_EN adds a sticky err_timeout for a stalled ack.
module ni_tx_injector
  import ni_tx_injector_pkg::*;
#(
  parameter int n     = 32,
  parameter int maxx  = 1,
  parameter int maxy  = 1,
  parameter int depth = 4
`ifdef NI_TX_TIMEOUT_EN
  , parameter int timeout = 1024
`endif
) (
  input  logic                   clk,
  input  logic                   rst,
  ni_tx_injector_if.slave        bus,
  output logic [$clog2(depth):0] fifo_count,
  output logic                   busy
`ifdef NI_TX_TIMEOUT_EN
  , output logic                 err_timeout
`endif
);
  ni_tx_state_t              state_q, state_d;
  logic                      out_req_q, out_req_d;
  logic [n-1:0]              out_data_q, out_data_d;
  logic [NI_SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
  logic                      ack_s;
  logic                      push, pop, fifo_full, fifo_empty;
  logic [n-1:0]              fifo_head;

  assign bus.in_ready = !fifo_full;
  assign push         = bus.in_valid && !fifo_full;
  assign pop          = (state_q == NI_IDLE) && !fifo_empty;
  assign ack_s        = ack_sync_q[NI_SYNC_STAGES-1];

  ni_tx_fifo #(.width(n), .depth(depth)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({bus.in_dst_x, bus.in_dst_y, bus.in_payload}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // SETUP holds data one full cycle before the req edge so the router sees settled data.
  always_comb begin
    state_d    = state_q;
    out_req_d  = out_req_q;
    out_data_d = out_data_q;
    ack_sync_d = {ack_sync_q[NI_SYNC_STAGES-2:0], bus.out_ack};
    unique case (state_q)
      NI_IDLE: begin
        if (!fifo_empty) begin
          out_data_d = fifo_head;
          state_d    = NI_SETUP;
        end
      end
      NI_SETUP: begin
        out_req_d = !out_req_q;
        state_d   = NI_WAIT;
      end
      NI_WAIT: begin
        if (ack_s == out_req_q) state_d = NI_IDLE;
      end
      default: state_d = NI_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= NI_IDLE;
      out_req_q  <= 1'b0;
      out_data_q <= '0;
      ack_sync_q <= '0;
    end else begin
      state_q    <= state_d;
      out_req_q  <= out_req_d;
      out_data_q <= out_data_d;
      ack_sync_q <= ack_sync_d;
    end
  end

  assign bus.out_req  = out_req_q;
  assign bus.out_data = out_data_q;
  assign busy         = (state_q != NI_IDLE) || (fifo_count != '0);

`ifdef NI_TX_TIMEOUT_EN
  localparam int TW = $clog2(timeout + 1);
  localparam logic [TW-1:0] TO_MAX = TW'(timeout);

  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic          err_q, err_d;

  // Counter saturates at the limit; the transfer itself keeps waiting.
  always_comb begin
    to_cnt_d = to_cnt_q;
    err_d    = err_q;
    if (state_q == NI_SETUP) begin
      to_cnt_d = '0;
    end else if (state_q == NI_WAIT && to_cnt_q != TO_MAX) begin
      to_cnt_d = to_cnt_q + 1'b1;
      if (to_cnt_q + 1'b1 == TO_MAX) err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      to_cnt_q <= to_cnt_d;
      err_q    <= err_d;
    end
  end

  assign err_timeout = err_q;
`endif

  a_no_spurious_ack: assert property (@(posedge clk) disable iff (rst)
    (state_q != NI_WAIT) |-> (ack_s == out_req_q));

endmodule

// File: tb/tb_ni_tx_injector.sv
// Self-checking bench for ni_tx_injector: scoreboard of pushed words versus
// words presented on each req toggle, plus directed latency/boundary checks.
module tb_ni_tx_injector;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] fifo_count;
  logic       busy;
`ifdef NI_TX_TIMEOUT_EN
  logic       err_timeout;
`endif

  ni_tx_injector_if #(.n(32), .maxx(1), .maxy(1)) bus ();

  ni_tx_injector #(
    .n(32), .maxx(1), .maxy(1), .depth(4)
`ifdef NI_TX_TIMEOUT_EN
    , .timeout(16)
`endif
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus.slave),
    .fifo_count (fifo_count),
    .busy       (busy)
`ifdef NI_TX_TIMEOUT_EN
    , .err_timeout (err_timeout)
`endif
  );

  always #5 clk = ~clk;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          n_deliv = 0;
  logic [31:0] exp_q[$];

  logic        mon_en = 1'b0;
  logic        prev_req = 1'b0, prev_ack = 1'b0;
  logic [31:0] prev_data = '0;

  logic        ack_hold = 1'b0;
  logic        rand_dly = 1'b0;
  int          ack_dly  = 0;
  int          rsp_cnt  = 0;
  int          rsp_lim  = 0;

  int          d0;
  int          i_poll;
  logic [29:0] rnd_pl;
  logic        rnd_dx, rnd_dy;
  logic [31:0] word_b;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push_pkt(input logic dx, input logic dy, input logic [29:0] pl);
    int i = 0;
    bus.in_dst_x   = dx;
    bus.in_dst_y   = dy;
    bus.in_payload = pl;
    bus.in_valid   = 1'b1;
    while (!bus.in_ready && i < 100) begin
      @(posedge clk); #1;
      i++;
    end
    if (!bus.in_ready) begin
      check_eq("push_timeout", 0, 1);
      bus.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      exp_q.push_back({dx, dy, pl});
      #1;
      bus.in_valid = 1'b0;
    end
  endtask

  task automatic wait_drain(input int budget);
    int i = 0;
    while ((busy || exp_q.size() != 0) && i < budget) begin
      @(posedge clk); #1;
      i++;
    end
    check_eq("drain", {31'b0, (busy || exp_q.size() != 0)}, 0);
  endtask

  // Scoreboard and bundled-data stability monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (mon_en) begin
        if (bus.out_req != prev_req) begin
          check_eq("setup_stable", bus.out_data, prev_data);
          if (exp_q.size() == 0) check_eq("spurious_pkt", 1, 0);
          else check_eq("order", bus.out_data, exp_q.pop_front());
          n_deliv++;
        end else if (prev_req != prev_ack) begin
          check_eq("hold_stable", bus.out_data, prev_data);
        end
      end
      prev_req  = bus.out_req;
      prev_ack  = bus.out_ack;
      prev_data = bus.out_data;
    end
  end

  // Router-side ack responder.
  initial begin
    bus.out_ack = 1'b0;
    forever begin
      @(posedge clk); #3;
      if (rst) begin
        bus.out_ack = 1'b0;
        rsp_cnt = 0;
      end else if (!ack_hold && bus.out_req != bus.out_ack) begin
        if (rsp_cnt == 0) rsp_lim = rand_dly ? int'($urandom_range(20, 0)) : ack_dly;
        rsp_cnt++;
        if (rsp_cnt > rsp_lim) begin
          bus.out_ack = bus.out_req;
          rsp_cnt = 0;
        end
      end else begin
        rsp_cnt = 0;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.in_dst_x = '0;
    bus.in_dst_y = '0;
    bus.in_payload = '0;
    repeat (3) @(posedge clk);
    @(negedge clk) rst = 1'b0;
    @(posedge clk); #1;

    check_eq("rst_out_req", 32'(bus.out_req), 0);
    check_eq("rst_out_data", bus.out_data, 0);
    check_eq("rst_fifo_count", 32'(fifo_count), 0);
    check_eq("rst_in_ready", 32'(bus.in_ready), 1);
    check_eq("rst_busy", 32'(busy), 0);
`ifdef NI_TX_TIMEOUT_EN
    check_eq("rst_err_timeout", 32'(err_timeout), 0);
`endif
    mon_en = 1'b1;

    // Single packet: latency E0 -> data at E1 -> req at E2; ack 3 cycles later.
    ack_dly = 3;
    push_pkt(1'b1, 1'b0, 30'h2AAAAAAA);
    check_eq("single_count", 32'(fifo_count), 1);
    @(posedge clk); #1;
    check_eq("single_data_e1", bus.out_data, 32'hAAAAAAAA);
    check_eq("single_req_e1", 32'(bus.out_req), 0);
    @(posedge clk); #1;
    check_eq("single_req_e2", 32'(bus.out_req), 1);
    repeat (5) @(posedge clk);
    #1;
    check_eq("single_busy_e7", 32'(busy), 1);
    @(posedge clk); #1;
    check_eq("single_busy_e8", 32'(busy), 0);
    check_eq("single_deliv", n_deliv, 1);

    // Fill to full with ack withheld.
    ack_hold = 1'b1;
    d0 = n_deliv;
    for (int k = 0; k < 5; k++) push_pkt(k[0], k[1], 30'(32'h100 + k));
    check_eq("full_in_ready", 32'(bus.in_ready), 0);
    check_eq("full_count", 32'(fifo_count), 4);
    bus.in_dst_x = 1'b1; bus.in_dst_y = 1'b1; bus.in_payload = 30'h3FFFFFFF;
    bus.in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    check_eq("full_no_push", 32'(fifo_count), 4);
    ack_hold = 1'b0;
    ack_dly = 2;
    wait_drain(300);
    check_eq("full_deliv", n_deliv - d0, 5);

    // Push on the same edge that IDLE pops, with two entries waiting.
    ack_hold = 1'b1;
    ack_dly = 0;
    d0 = n_deliv;
    push_pkt(1'b0, 1'b1, 30'h0000A0A0);
    push_pkt(1'b1, 1'b1, 30'h0000B0B0);
    word_b = {1'b1, 1'b1, 30'h0000B0B0};
    push_pkt(1'b0, 1'b0, 30'h0000C0C0);
    repeat (3) @(posedge clk);
    #1;
    check_eq("sim_count_pre", 32'(fifo_count), 2);
    ack_hold = 1'b0;
    i_poll = 0;
    while (bus.out_ack != bus.out_req && i_poll < 20) begin
      @(posedge clk); #1;
      i_poll++;
    end
    check_eq("sim_ack_seen", 32'(bus.out_ack == bus.out_req), 1);
    repeat (2) @(posedge clk);
    #1;
    check_eq("sim_count_before", 32'(fifo_count), 2);
    push_pkt(1'b1, 1'b0, 30'h0000D0D0);
    check_eq("sim_count_after", 32'(fifo_count), 2);
    check_eq("sim_popped_b", bus.out_data, word_b);
    wait_drain(200);
    check_eq("sim_deliv", n_deliv - d0, 4);

    // Random ack delays 0..20 over 50 packets.
    rand_dly = 1'b1;
    d0 = n_deliv;
    for (int k = 0; k < 50; k++) begin
      rnd_pl = 30'($urandom);
      rnd_dx = 1'($urandom);
      rnd_dy = 1'($urandom);
      push_pkt(rnd_dx, rnd_dy, rnd_pl);
      repeat ($urandom_range(3, 0)) @(posedge clk);
      #1;
    end
    wait_drain(3000);
    check_eq("sweep_deliv", n_deliv - d0, 50);
    rand_dly = 1'b0;

    // Reset while waiting for an ack, with a second packet queued.
    ack_hold = 1'b1;
    push_pkt(1'b0, 1'b1, 30'h12345);
    push_pkt(1'b1, 1'b0, 30'h6789A);
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_mid_req", 32'(bus.out_req), 1);
    check_eq("rst_mid_count", 32'(fifo_count), 1);
    mon_en = 1'b0;
    @(negedge clk) rst = 1'b1;
    @(negedge clk) rst = 1'b0;
    check_eq("rst_mid_out_req", 32'(bus.out_req), 0);
    check_eq("rst_mid_out_data", bus.out_data, 0);
    check_eq("rst_mid_fifo_count", 32'(fifo_count), 0);
    check_eq("rst_mid_in_ready", 32'(bus.in_ready), 1);
    check_eq("rst_mid_busy", 32'(busy), 0);
    exp_q.delete();
    ack_hold = 1'b0;
    @(posedge clk); #1;
    check_eq("rst_next_out_req", 32'(bus.out_req), 0);
    mon_en = 1'b1;

`ifdef NI_TX_TIMEOUT_EN
    ack_hold = 1'b1;
    push_pkt(1'b1, 1'b1, 30'h0BADBEEF);
    repeat (2) @(posedge clk);
    #1;
    check_eq("to_req", 32'(bus.out_req), 1);
    repeat (15) @(posedge clk);
    #1;
    check_eq("to_err_15", 32'(err_timeout), 0);
    @(posedge clk); #1;
    check_eq("to_err_16", 32'(err_timeout), 1);
    ack_hold = 1'b0;
    wait_drain(50);
    check_eq("to_err_sticky", 32'(err_timeout), 1);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
